alu_wb_buffer: RTL and testbench

ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

---
 rtl/alu_wb_buffer.sv | 74 +++++++
 tb/tb_alu_wb_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// alu_wb_buffer: per-lane FIFOs decoupling ALU results from the writeback port
package config_pkg;
    typedef struct packed {
        int unsigned NrALUs;
        int unsigned XLEN;
        int unsigned TRANS_ID_BITS;
    } cva6_cfg_t;
    localparam cva6_cfg_t cva6_cfg_empty = '{NrALUs: 2, XLEN: 64, TRANS_ID_BITS: 3};
endpackage

module alu_wb_buffer #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter int Depth = 2
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic                                            flush_i,
    input  logic [CVA6Cfg.NrALUs-1:0]                       alu_valid_i,
    input  logic [CVA6Cfg.NrALUs*CVA6Cfg.TRANS_ID_BITS-1:0] alu_trans_id_i,
    input  logic [CVA6Cfg.NrALUs*CVA6Cfg.XLEN-1:0]          alu_result_i,
    output logic [CVA6Cfg.NrALUs-1:0]                       alu_ready_o,
    output logic [CVA6Cfg.NrALUs-1:0]                       wb_valid_o,
    output logic [CVA6Cfg.NrALUs*CVA6Cfg.TRANS_ID_BITS-1:0] wb_trans_id_o,
    output logic [CVA6Cfg.NrALUs*CVA6Cfg.XLEN-1:0]          wb_result_o,
    input  logic [CVA6Cfg.NrALUs-1:0]                       wb_ready_i,
    output logic [CVA6Cfg.NrALUs*($clog2(Depth)+1)-1:0]     occupancy_o
);
    localparam int NA = int'(CVA6Cfg.NrALUs);
    localparam int XL = int'(CVA6Cfg.XLEN);
    localparam int TB = int'(CVA6Cfg.TRANS_ID_BITS);
    localparam int PW = $clog2(Depth);
    localparam int OW = PW + 1;

    for (genvar l = 0; l < NA; l++) begin : gen_lane
        logic [PW-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
        logic [OW-1:0]    cnt_q, cnt_d;
        logic [TB+XL-1:0] mem_q [Depth];
        logic [TB+XL-1:0] mem_d [Depth];
        logic             push, pop;

        assign alu_ready_o[l]           = cnt_q != OW'(Depth);
        assign wb_valid_o[l]            = cnt_q != '0;
        assign wb_trans_id_o[l*TB +: TB] = mem_q[rptr_q][XL +: TB];
        assign wb_result_o[l*XL +: XL]   = mem_q[rptr_q][XL-1:0];
        assign occupancy_o[l*OW +: OW]   = cnt_q;
        assign push = alu_valid_i[l] & alu_ready_o[l] & ~flush_i;
        assign pop  = wb_valid_o[l] & wb_ready_i[l] & ~flush_i;

        // next pointers/count; power-of-two depth lets pointers wrap by overflow
        always_comb begin
            rptr_d = flush_i ? '0 : rptr_q + PW'(pop);
            wptr_d = flush_i ? '0 : wptr_q + PW'(push);
            cnt_d  = flush_i ? '0 : cnt_q + OW'(push) - OW'(pop);
            mem_d  = mem_q;
            if (push) mem_d[wptr_q] = {alu_trans_id_i[l*TB +: TB], alu_result_i[l*XL +: XL]};
        end

        // control state, cleared immediately by reset
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rptr_q <= '0;
                wptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                rptr_q <= rptr_d;
                wptr_q <= wptr_d;
                cnt_q  <= cnt_d;
            end
        end

        // entry storage, never reset since occupancy gates visibility
        always_ff @(posedge clk_i) mem_q <= mem_d;
    end
endmodule

// File: tb/tb_alu_wb_buffer.sv
// tb_alu_wb_buffer: vector table, scoreboarded random traffic, flush and async reset sequences
module tb_alu_wb_buffer;
    localparam int NA = 2, XL = 64, TB = 3, D = 2, OW = 2;

    logic              clk = 0, rst = 1, flush = 0;
    logic [NA-1:0]     av = '0, ardy, wbv, wrdy = '0;
    logic [NA*TB-1:0]  aid = '0, wid;
    logic [NA*XL-1:0]  ares = '0, wres;
    logic [NA*OW-1:0]  occ;
    int checks = 0, errors = 0;

    typedef struct {
        logic        v;
        logic [2:0]  id;
        logic [63:0] res;
        logic        rdy;
        logic        e_ardy, e_wbv;
        logic [2:0]  e_id;
        logic [63:0] e_res;
        logic [1:0]  e_occ;
    } vec_t;
    vec_t tbl[$];

    typedef logic [TB+XL-1:0] ent_t;
    ent_t mq [NA][$];

    alu_wb_buffer #(.Depth(D)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .alu_valid_i(av), .alu_trans_id_i(aid), .alu_result_i(ares),
        .alu_ready_o(ardy), .wb_valid_o(wbv), .wb_trans_id_o(wid),
        .wb_result_o(wres), .wb_ready_i(wrdy), .occupancy_o(occ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [2:0] id, input logic [63:0] res, input logic rdy,
                       input logic e_ardy, input logic e_wbv, input logic [2:0] e_id,
                       input logic [63:0] e_res, input logic [1:0] e_occ);
        vec_t t;
        t = '{v, id, res, rdy, e_ardy, e_wbv, e_id, e_res, e_occ};
        tbl.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // vectors for lane 0: inputs driven this cycle, outputs expected before its edge
        add(0, 0, 0,      0, 1, 0, 0, 0,      0);
        add(1, 3, 'h1234, 1, 1, 0, 0, 0,      0);
        add(0, 0, 0,      1, 1, 1, 3, 'h1234, 1);
        add(0, 0, 0,      0, 1, 0, 0, 0,      0);
        add(1, 1, 'h11,   0, 1, 0, 0, 0,      0);
        add(1, 2, 'h22,   0, 1, 1, 1, 'h11,   1);
        add(1, 3, 'h33,   0, 0, 1, 1, 'h11,   2);
        add(0, 0, 0,      0, 0, 1, 1, 'h11,   2);
        add(1, 4, 'h44,   1, 0, 1, 1, 'h11,   2);
        add(0, 0, 0,      0, 1, 1, 2, 'h22,   1);
        add(1, 6, 'h66,   0, 1, 1, 2, 'h22,   1);
        add(0, 0, 0,      1, 0, 1, 2, 'h22,   2);
        add(0, 0, 0,      1, 1, 1, 6, 'h66,   1);
        add(0, 0, 0,      0, 1, 0, 0, 0,      0);
        add(1, 0, 'h50,   0, 1, 0, 0, 0,      0);
        for (int k = 0; k < 10; k++)
            add(1, 5, 64'('h500 + k), 1, 1, 1, (k == 0) ? 3'd0 : 3'd5,
                (k == 0) ? 64'h50 : 64'('h500 + k - 1), 1);
        add(0, 0, 0,      0, 1, 1, 5, 'h509,  1);
        add(0, 0, 0,      1, 1, 1, 5, 'h509,  1);
        add(0, 0, 0,      0, 1, 0, 0, 0,      0);

        #2;
        chk("rst_ardy", 64'(ardy), 64'(2'b11));
        chk("rst_wbv", 64'(wbv), 0);
        chk("rst_occ", 64'(occ), 0);
        step();
        step();
        rst = 0;

        foreach (tbl[i]) begin
            av[0] = tbl[i].v;
            aid[TB-1:0] = tbl[i].id;
            ares[XL-1:0] = tbl[i].res;
            wrdy[0] = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_occ", i), 64'(occ[OW-1:0]), 64'(tbl[i].e_occ));
            chk($sformatf("vec%0d_ardy", i), 64'(ardy[0]), 64'(tbl[i].e_ardy));
            chk($sformatf("vec%0d_wbv", i), 64'(wbv[0]), 64'(tbl[i].e_wbv));
            chk($sformatf("vec%0d_lane1_occ", i), 64'(occ[2*OW-1:OW]), 0);
            if (tbl[i].e_wbv) begin
                chk($sformatf("vec%0d_id", i), 64'(wid[TB-1:0]), 64'(tbl[i].e_id));
                chk($sformatf("vec%0d_res", i), wres[XL-1:0], tbl[i].e_res);
            end
            step();
        end
        av = '0;
        wrdy = '0;

        for (int c = 0; c < 400; c++) begin
            flush = ($urandom_range(0, 29) == 0);
            for (int l = 0; l < NA; l++) begin
                av[l] = 1'($urandom_range(0, 1));
                aid[l*TB +: TB] = 3'($urandom);
                ares[l*XL +: XL] = {$urandom, $urandom};
                wrdy[l] = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            for (int l = 0; l < NA; l++) begin
                chk($sformatf("rnd%0d_l%0d_occ", c, l), 64'(occ[l*OW +: OW]), 64'(mq[l].size()));
                chk($sformatf("rnd%0d_l%0d_ardy", c, l), 64'(ardy[l]), 64'(mq[l].size() < D));
                chk($sformatf("rnd%0d_l%0d_wbv", c, l), 64'(wbv[l]), 64'(mq[l].size() != 0));
                if (mq[l].size() != 0) begin
                    chk($sformatf("rnd%0d_l%0d_id", c, l), 64'(wid[l*TB +: TB]), 64'(mq[l][0][XL +: TB]));
                    chk($sformatf("rnd%0d_l%0d_res", c, l), wres[l*XL +: XL], mq[l][0][XL-1:0]);
                end
            end
            for (int l = 0; l < NA; l++) begin
                if (flush) mq[l].delete();
                else begin
                    automatic bit can_push = av[l] && mq[l].size() < D;
                    if (wrdy[l] && mq[l].size() != 0) void'(mq[l].pop_front());
                    if (can_push) mq[l].push_back({aid[l*TB +: TB], ares[l*XL +: XL]});
                end
            end
            step();
        end
        flush = 1;
        av = '0;
        wrdy = '0;
        step();
        flush = 0;

        av = 2'b11;
        aid = {3'd1, 3'd1};
        step();
        aid = {3'd2, 3'd2};
        step();
        @(negedge clk);
        chk("fl_pre_occ", 64'(occ), 64'({2'd2, 2'd2}));
        aid = {3'd4, 3'd4};
        flush = 1;
        step();
        flush = 0;
        av = '0;
        @(negedge clk);
        chk("fl_occ", 64'(occ), 0);
        chk("fl_wbv", 64'(wbv), 0);
        chk("fl_ardy", 64'(ardy), 64'(2'b11));
        step();
        @(negedge clk);
        chk("fl_after_occ", 64'(occ), 0);
        chk("fl_after_wbv", 64'(wbv), 0);

        av = 2'b01;
        aid = {3'd0, 3'd2};
        ares[XL-1:0] = 64'h22;
        step();
        av = '0;
        @(negedge clk);
        chk("ar_pre_wbv", 64'(wbv[0]), 1);
        #2;
        rst = 1;
        #1;
        chk("ar_wbv", 64'(wbv), 0);
        chk("ar_occ", 64'(occ), 0);
        chk("ar_ardy", 64'(ardy), 64'(2'b11));
        step();
        rst = 0;
        av = 2'b01;
        aid = {3'd0, 3'd7};
        ares[XL-1:0] = 64'h77;
        step();
        av = '0;
        @(negedge clk);
        chk("ar_post_occ", 64'(occ[OW-1:0]), 1);
        chk("ar_post_id", 64'(wid[TB-1:0]), 7);
        chk("ar_post_res", wres[XL-1:0], 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
